// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared op codes, FSM states and widths for the dual-port RAM port master
package dpram_pkg;

    localparam int DPRAM_ADDR_W = 16;
    localparam int DPRAM_DATA_W = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT1 = 3'd1;
    localparam logic [2:0] ST_RD_WAIT2 = 3'd2;
    localparam logic [2:0] ST_RD_RESP  = 3'd3;
    localparam logic [2:0] ST_WR       = 3'd4;
    localparam logic [2:0] ST_ERR      = 3'd5;

endpackage

// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - sequences load/store/fill requests onto one dual-port RAM port
module dpram_port_master
    import dpram_pkg::*;
#(
    parameter int ADDR_W = DPRAM_ADDR_W,
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              en_q, en_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        en_d     = en_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_READ: begin
                            addr_d  = req_addr;
                            cnt_d   = req_len;
                            en_d    = 1'b0;
                            state_d = ST_RD_WAIT1;
                        end
                        OP_WRITE, OP_FILL: begin
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                            cnt_d   = (req_op == OP_FILL) ? req_len : '0;
                            en_d    = 1'b1;
                            state_d = ST_WR;
                        end
                        default: state_d = ST_ERR;
                    endcase
                end
            end
            ST_RD_WAIT1: state_d = ST_RD_WAIT2;
            // ram_rdata now reflects the address sampled one edge earlier
            ST_RD_WAIT2: begin
                rdata_d  = ram_rdata;
                rvalid_d = 1'b1;
                state_d  = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = ST_RD_WAIT1;
                    end
                end
            end
            ST_WR: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - CNT_ONE;
                end
            end
            ST_ERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            en_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            en_q     <= en_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ram_en     = en_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;

endmodule
